card_reader_if: RTL and testbench
=================================

# card_reader_if

Front-end for the door controller. It receives Wiegand-style 26-bit card frames from the reader's two data lines and checks both parity bits. It then compares the 24-bit card ID against a small programmable allow-list and drives a held `card_valid` level. The door FSM samples that level at the end of its card-scan wait.

## Interface
- `TIMEOUT_CYC`, default 16: idle clk cycles between bit strobes before a partial frame is aborted.
- `HOLD_CYC`, default 32: clk cycles that `card_valid` stays asserted after a match.
- `NUM_ENTRIES`, default 4: allow-list size, a power of two; the address width is log2(NUM_ENTRIES).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `rd_d0` in 1: reader "0" line, active-high pulse, asynchronous to clk.
- `rd_d1` in 1: reader "1" line, active-high pulse, asynchronous to clk.
- `prog_we` in 1: allow-list write strobe.
- `prog_addr` in log2(NUM_ENTRIES): entry index.
- `prog_id` in 24: ID to store.
- `prog_en` in 1: entry-valid bit written with the ID.
- `card_valid` out 1: held high for HOLD_CYC cycles after a parity-good, listed card.
- `card_done` out 1: one-cycle pulse when any complete 26-bit frame has been checked.
- `card_id` out 24: ID of the last completed frame.
- `parity_err` out 1: last completed frame failed parity; held until the next completed frame.
- `frame_err` out 1: one-cycle pulse on abort, either by timeout or by both lines in one cycle.

## Operation
- **Input path.**
  - Each data line goes through a 2-flop synchronizer, then a rising-edge detect.
  - An edge on d0 is a 0-bit strobe; an edge on d1 is a 1-bit strobe.
  - Edges on both lines in the same cycle are a framing error.
- **Frame format.** The first received bit is frame bit 0.
  - Bit 0: even parity over bits 1..12. The XOR of bits 0..12 must be 0.
  - Bits 1..24: ID, MSB first. Bit 1 is ID[23].
  - Bit 25: odd parity over bits 13..24. The XOR of bits 13..25 must be 1.
- **FSM states.** IDLE, RECV, CHECK, HOLD.
  - IDLE: a bit strobe captures bit 0, sets bit_cnt=1 and goes to RECV.
  - RECV:
    - Each strobe shifts the bit in, increments bit_cnt and clears the timeout counter.
    - When bit_cnt reaches 26, go to CHECK.
    - A timeout counter reaching TIMEOUT_CYC, or a both-line strobe: pulse frame_err, clear the shift register and bit_cnt, go to IDLE. card_id and parity_err are unchanged.
  - CHECK lasts one cycle:
    - Evaluate parity.
    - Compare the ID against every entry whose valid bit is set, in parallel.
    - Register card_id, parity_err, card_done=1 and card_valid = (parity ok AND any match).
    - Go to HOLD.
  - HOLD:
    - Count up to HOLD_CYC, then clear card_valid and go to IDLE.
    - A bit strobe during HOLD clears card_valid on that edge, captures the bit as bit 0 and goes to RECV.
    - Strobes arriving during CHECK are ignored.
- **Allow-list.**
  - On prog_we, write {prog_en, prog_id} to entry prog_addr at the clock edge.
  - A write in the same cycle as CHECK is not seen by that compare; CHECK uses the old contents.
  - Duplicate IDs across entries are legal; any match counts.
- **Arithmetic and widths.**
  - bit_cnt is 5 bits and never exceeds 26.
  - The timeout and hold counters are sized to their parameter and saturate; they do not wrap.

## Timing
- **Reset values.**
  - card_valid=0, card_done=0, card_id=0, parity_err=0, frame_err=0.
  - FSM in IDLE; all counters at 0.
  - All allow-list valid bits at 0, so no card matches until the list is programmed.
  - Synchronizer flops at 0.
- **Latency.**
  - Line edge to internal strobe: 3 clk cycles (2 sync + 1 edge register).
  - Last strobe sampled at edge N: state is CHECK after N; outputs are valid after N+1 (card_done high for cycle N+1..N+2).
  - card_valid is high for exactly HOLD_CYC cycles when no new frame starts.
- **Boundaries.**
  - Reset mid-frame discards the partial frame with no frame_err.
  - A timeout with bit_cnt=25 still aborts.
  - A strobe on the same cycle the timeout counter reaches TIMEOUT_CYC is accepted as a bit, and the timeout counter clears.
  - Lines held high produce only one strobe.
- **Downstream contract.** The door FSM samples card_valid at least 4 cycles after it sees the sensor. The reader sequence must complete before that, and HOLD_CYC ≥ 8 is required.

## Test plan
- **Reset default.** Reset, then send a valid frame for ID 24'h000001 with the list empty -> card_done pulse, card_valid=0, parity_err=0, card_id=24'h000001.
- **Listed card.** Program entry 0 = {1, 24'h000001}. Send frame bits 0, then 23 zeros, then 1, then 0 (26 strobes) -> card_valid=1 two cycles after the last strobe, held 32 cycles, then 0.
- **Parity error.** Same frame with bit 25 = 1 -> card_done=1, parity_err=1, card_valid=0.
- **Timeout.** Send 10 bits, then idle for 16 cycles -> frame_err single pulse, FSM in IDLE. A following complete listed frame is still accepted.
- **Framing error.** Rising edges on rd_d0 and rd_d1 in the same cycle mid-frame -> frame_err pulse, frame aborted.
- **Restart and revocation.**
  - A new frame starting during HOLD -> card_valid drops on the first strobe.
  - Writing entry 0 with prog_en=0 in the CHECK cycle of the next frame -> that frame still matches.
  - The frame after that -> card_valid=0.

Source files
------------

// File: rtl/card_reader_if.sv
// Wiegand 26-bit card front-end: synchronises the reader lines, assembles and
// parity-checks frames, and matches the ID against a programmable allow-list.
module card_reader_if #(
    parameter int TIMEOUT_CYC = 16,
    parameter int HOLD_CYC    = 32,
    parameter int NUM_ENTRIES = 4,
    localparam int AW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_d0,
    input  logic          rd_d1,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [23:0]   prog_id,
    input  logic          prog_en,
    output logic          card_valid,
    output logic          card_done,
    output logic [23:0]   card_id,
    output logic          parity_err,
    output logic          frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK, HOLD} state_t;

    state_t state_reg, state_next;

    logic d0_meta_reg, d0_sync_reg, d0_prev_reg;
    logic d1_meta_reg, d1_sync_reg, d1_prev_reg;
    logic str0, str1, bit_strobe, both_strobe;

    logic [25:0]   shift_reg, shift_next;
    logic [4:0]    bit_cnt_reg, bit_cnt_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic [HW-1:0] hold_reg, hold_next;

    logic        card_valid_reg, card_valid_next;
    logic        card_done_reg, card_done_next;
    logic [23:0] card_id_reg, card_id_next;
    logic        parity_err_reg, parity_err_next;
    logic        frame_err_reg, frame_err_next;

    logic [NUM_ENTRIES-1:0] entry_valid_reg;
    logic [23:0]            entry_id_reg [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] hit;
    logic                   parity_ok;

    // Two-flop synchroniser per line; the third flop is the edge-detect history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0_meta_reg <= 1'b0;
            d0_sync_reg <= 1'b0;
            d0_prev_reg <= 1'b0;
            d1_meta_reg <= 1'b0;
            d1_sync_reg <= 1'b0;
            d1_prev_reg <= 1'b0;
        end else begin
            d0_meta_reg <= rd_d0;
            d0_sync_reg <= d0_meta_reg;
            d0_prev_reg <= d0_sync_reg;
            d1_meta_reg <= rd_d1;
            d1_sync_reg <= d1_meta_reg;
            d1_prev_reg <= d1_sync_reg;
        end
    end

    assign str0        = d0_sync_reg & ~d0_prev_reg;
    assign str1        = d1_sync_reg & ~d1_prev_reg;
    assign bit_strobe  = str0 ^ str1;
    assign both_strobe = str0 & str1;

    // Allow-list is held in flops so every entry can be compared in one cycle.
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    entry_valid_reg[gi] <= 1'b0;
                    entry_id_reg[gi]    <= 24'd0;
                end else if (prog_we && prog_addr == AW'(gi)) begin
                    entry_valid_reg[gi] <= prog_en;
                    entry_id_reg[gi]    <= prog_id;
                end
            end
            assign hit[gi] = entry_valid_reg[gi] && (entry_id_reg[gi] == shift_reg[24:1]);
        end
    endgenerate

    // shift_reg[25] holds frame bit 0, shift_reg[0] holds frame bit 25.
    assign parity_ok = ~(^shift_reg[25:13]) & (^shift_reg[12:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg      <= 26'd0;
            bit_cnt_reg    <= 5'd0;
            tmo_reg        <= '0;
            hold_reg       <= '0;
            card_valid_reg <= 1'b0;
            card_done_reg  <= 1'b0;
            card_id_reg    <= 24'd0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            tmo_reg        <= tmo_next;
            hold_reg       <= hold_next;
            card_valid_reg <= card_valid_next;
            card_done_reg  <= card_done_next;
            card_id_reg    <= card_id_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        tmo_next        = tmo_reg;
        hold_next       = hold_reg;
        card_valid_next = card_valid_reg;
        card_done_next  = 1'b0;
        card_id_next    = card_id_reg;
        parity_err_next = parity_err_reg;
        frame_err_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bit_strobe) begin
                    shift_next   = {25'd0, str1};
                    bit_cnt_next = 5'd1;
                    tmo_next     = '0;
                    state_next   = RECV;
                end
            end
            RECV: begin
                if (both_strobe || (!bit_strobe && tmo_reg == TMO_MAX)) begin
                    shift_next     = 26'd0;
                    bit_cnt_next   = 5'd0;
                    tmo_next       = '0;
                    frame_err_next = 1'b1;
                    state_next     = IDLE;
                end else if (bit_strobe) begin
                    shift_next   = {shift_reg[24:0], str1};
                    bit_cnt_next = bit_cnt_reg + 5'd1;
                    tmo_next     = '0;
                    if (bit_cnt_reg == 5'd25) begin
                        state_next = CHECK;
                    end
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            CHECK: begin
                card_id_next    = shift_reg[24:1];
                parity_err_next = ~parity_ok;
                card_done_next  = 1'b1;
                card_valid_next = parity_ok & (|hit);
                hold_next       = '0;
                bit_cnt_next    = 5'd0;
                state_next      = HOLD;
            end
            HOLD: begin
                // A new frame pre-empts the hold window.
                if (bit_strobe) begin
                    card_valid_next = 1'b0;
                    shift_next      = {25'd0, str1};
                    bit_cnt_next    = 5'd1;
                    tmo_next        = '0;
                    state_next      = RECV;
                end else if (hold_reg == HOLD_LAST) begin
                    card_valid_next = 1'b0;
                    state_next      = IDLE;
                end else begin
                    hold_next = hold_reg + HW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign card_valid = card_valid_reg;
    assign card_done  = card_done_reg;
    assign card_id    = card_id_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_card_reader_if.sv
// Directed bench for card_reader_if: expected frame results are queued when a
// frame is sent and compared when card_done fires.
module tb_card_reader_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_d0, rd_d1;
    logic        prog_we, prog_en;
    logic [1:0]  prog_addr;
    logic [23:0] prog_id;
    logic        card_valid, card_done, parity_err, frame_err;
    logic [23:0] card_id;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [23:0] id;
        logic        perr;
        logic        valid;
    } exp_t;

    exp_t        exp_q[$];
    logic        m_valid [4];
    logic [23:0] m_id [4];
    logic [23:0] last_id;

    always #5 clk = ~clk;

    card_reader_if dut (
        .clk        (clk),
        .reset      (reset),
        .rd_d0      (rd_d0),
        .rd_d1      (rd_d1),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_id    (prog_id),
        .prog_en    (prog_en),
        .card_valid (card_valid),
        .card_done  (card_done),
        .card_id    (card_id),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [25:0] frame_bits(input logic [23:0] id, input logic corrupt);
        logic [25:0] f;
        f[0] = ^id[23:12];
        for (int i = 0; i < 24; i++) f[1+i] = id[23-i];
        f[25] = ~(^id[11:0]) ^ corrupt;
        return f;
    endfunction

    function automatic logic listed(input logic [23:0] id);
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && m_id[i] == id) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic send_bit(input logic b);
        repeat (2) @(negedge clk);
        if (b) rd_d1 = 1'b1;
        else   rd_d0 = 1'b1;
        repeat (2) @(negedge clk);
        rd_d0 = 1'b0;
        rd_d1 = 1'b0;
    endtask

    task automatic send_both();
        repeat (2) @(negedge clk);
        rd_d0 = 1'b1;
        rd_d1 = 1'b1;
        repeat (2) @(negedge clk);
        rd_d0 = 1'b0;
        rd_d1 = 1'b0;
    endtask

    task automatic push_frame(input logic [23:0] id, input logic corrupt);
        exp_t e;
        e.id    = id;
        e.perr  = corrupt;
        e.valid = !corrupt && listed(id);
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [23:0] id, input logic corrupt);
        logic [25:0] f;
        f = frame_bits(id, corrupt);
        push_frame(id, corrupt);
        for (int i = 0; i < 26; i++) send_bit(f[i]);
    endtask

    task automatic prog(input logic [1:0] a, input logic [23:0] id, input logic en);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_id = id; prog_en = en;
        @(negedge clk);
        prog_we = 1'b0;
        m_valid[a] = en;
        m_id[a]    = id;
        $display("prog entry=%0d id=%h en=%0d", a, id, en);
    endtask

    task automatic wait_done(input int exp_lat, input bit do_hold);
        int   lat;
        int   cnt;
        exp_t e;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (card_done === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("done_seen", 32'(lat != 0), 32'd1);
        if (lat == 0) return;
        chk("done_latency", 32'(lat), 32'(exp_lat));
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=nonzero", exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        last_id = e.id;
        chk("card_id", 32'(card_id), 32'(e.id));
        chk("parity_err", 32'(parity_err), 32'(e.perr));
        chk("card_valid", 32'(card_valid), 32'(e.valid));
        $display("frame id=%h parity_err=%0d card_valid=%0d latency=%0d",
                 card_id, parity_err, card_valid, lat);
        if (do_hold) begin
            cnt = 1;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                if (i == 0) chk("done_pulse_width", 32'(card_done), 32'd0);
                if (card_valid !== 1'b1) break;
                cnt++;
            end
            chk("hold_cycles", 32'(cnt), 32'd32);
            $display("hold id=%h valid_cycles=%0d", last_id, cnt);
        end
    endtask

    task automatic wait_ferr(input int exp_lat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (frame_err === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("ferr_seen", 32'(lat != 0), 32'd1);
        if (lat == 0) return;
        chk("ferr_latency", 32'(lat), 32'(exp_lat));
        chk("ferr_card_id_kept", 32'(card_id), 32'(last_id));
        @(posedge clk); #1;
        chk("ferr_pulse_width", 32'(frame_err), 32'd0);
        $display("abort frame_err latency=%0d card_id=%h", lat, card_id);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [25:0] f;
        int          fe;
        reset = 1'b1; rd_d0 = 1'b0; rd_d1 = 1'b0;
        prog_we = 1'b0; prog_en = 1'b0; prog_addr = 2'd0; prog_id = 24'd0;
        last_id = 24'd0;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_id[i]    = 24'd0;
        end
        repeat (3) @(negedge clk);
        chk("rst_card_valid", 32'(card_valid), 32'd0);
        chk("rst_card_done", 32'(card_done), 32'd0);
        chk("rst_card_id", 32'(card_id), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;

        // Empty list: good frame is reported but not valid.
        send_frame(24'h000001, 1'b0);
        wait_done(2, 1'b0);

        // Listed card, full hold window.
        prog(2'd0, 24'h000001, 1'b1);
        send_frame(24'h000001, 1'b0);
        wait_done(2, 1'b1);

        // Bad trailing parity.
        send_frame(24'h000001, 1'b1);
        wait_done(2, 1'b0);

        // Timeout after 10 bits, then a normal frame.
        f = frame_bits(24'h000001, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        wait_ferr(18);
        send_frame(24'h000001, 1'b0);
        wait_done(2, 1'b1);

        // Both lines in one cycle mid-frame.
        for (int i = 0; i < 5; i++) send_bit(f[i]);
        send_both();
        wait_ferr(1);

        // Restart during hold, with revocation written in the CHECK cycle.
        send_frame(24'h000001, 1'b0);
        wait_done(2, 1'b0);
        push_frame(24'h000001, 1'b0);
        send_bit(f[0]);
        chk("valid_before_restart", 32'(card_valid), 32'd1);
        @(posedge clk); #1;
        chk("valid_drop_on_strobe", 32'(card_valid), 32'd0);
        for (int i = 1; i < 26; i++) send_bit(f[i]);
        @(posedge clk);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 2'd0; prog_id = 24'h000001; prog_en = 1'b0;
        wait_done(1, 1'b0);
        prog_we = 1'b0;
        m_valid[0] = 1'b0;
        $display("prog entry=0 id=000001 en=0 (during check)");
        send_frame(24'h000001, 1'b0);
        wait_done(2, 1'b0);

        // Reset mid-frame: no abort pulse, everything cleared.
        f = frame_bits(24'hABCDEF, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(f[i]);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_card_id", 32'(card_id), 32'd0);
        chk("async_rst_card_valid", 32'(card_valid), 32'd0);
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        last_id = 24'd0;
        @(negedge clk);
        reset = 1'b0;
        fe = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (frame_err === 1'b1) fe++;
        end
        chk("no_ferr_after_reset", 32'(fe), 32'd0);
        $display("reset mid-frame frame_err_pulses=%0d", fe);

        // Multiple entries, including a higher index.
        prog(2'd3, 24'hABCDEF, 1'b1);
        prog(2'd1, 24'h5A5A5A, 1'b1);
        send_frame(24'hABCDEF, 1'b0);
        wait_done(2, 1'b1);
        send_frame(24'h5A5A5A, 1'b0);
        wait_done(2, 1'b0);
        send_frame(24'h123456, 1'b0);
        wait_done(2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
